// File: rtl/pipe_ctrl.sv
// pipe_ctrl: sequencing controller for the five-stage pipeline.
// It turns load-use hazards, EX-stage redirects and multi-cycle data-memory
// accesses into write-enable/clear controls for the four pipe registers and
// the PC. It also keeps stall and flush performance counters.
//
// Ports:
//   clk, reset             clock (rising edge), asynchronous active-high reset
//   id_rs1/id_rs2          source register indices of the ID instruction
//   id_use_rs1/id_use_rs2  the ID instruction actually reads rs1 / rs2
//   ex_rd, ex_mem_read     destination and is-load flag of the EX instruction
//   ex_redirect            taken branch or jump resolved in EX
//   mem_access             the MEM instruction is a load or store
//   pc_we, *_we, *_clr     PC enable and pipe register enables/clears
//   mem_ready              data memory result is valid this cycle
//   stall_cycles           cycles with pc_we=0 (wraps)
//   flush_events           redirects acted on (wraps)
module pipe_ctrl #(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_redirect,
    input  logic             mem_access,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             idex_we,
    output logic             exmem_we,
    output logic             memwb_we,
    output logic             ifid_clr,
    output logic             idex_clr,
    output logic             exmem_clr,
    output logic             memwb_clr,
    output logic             mem_ready,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Wait counter holds the remaining WAIT cycles; one bit minimum when
    // the memory is single-cycle and the counter is never used.
    localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;

    typedef enum logic [1:0] {
        RUN,
        WAIT,
        RELEASE
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          mem_stall;
    logic          load_use;
    logic          redirect_act;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= RUN;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Memory wait sequencing. The RUN cycle that first sees the access is
    // itself a stall cycle, so WAIT only covers the remaining MEM_LAT-1.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        mem_stall  = 1'b0;
        case (state_reg)
            RUN: begin
                if (MEM_LAT > 0 && mem_access) begin
                    mem_stall = 1'b1;
                    if (MEM_LAT == 1) begin
                        state_next = RELEASE;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = CW'(MEM_LAT - 1);
                    end
                end
            end
            WAIT: begin
                mem_stall = 1'b1;
                cnt_next  = cnt_reg - CW'(1);
                if (cnt_reg == CW'(1)) begin
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                // mem_access is ignored here: it still shows the op that
                // just completed, not a new one.
                state_next = RUN;
            end
            default: begin
                state_next = RUN;
            end
        endcase
    end

    assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (ex_rd == id_rs1)) ||
                       (id_use_rs2 && (ex_rd == id_rs2)));

    // A redirect is only acted on when EX is not frozen by memory.
    assign redirect_act = ex_redirect && !mem_stall;

    always_comb begin
        pc_we     = 1'b1;
        ifid_we   = 1'b1;
        idex_we   = 1'b1;
        exmem_we  = 1'b1;
        memwb_we  = 1'b1;
        ifid_clr  = 1'b0;
        idex_clr  = 1'b0;
        exmem_clr = 1'b0;
        memwb_clr = 1'b0;
        mem_ready = (MEM_LAT == 0) ? mem_access : (state_reg == RELEASE);
        if (mem_stall) begin
            // Freeze IF..MEM and push a bubble into WB.
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            idex_we   = 1'b0;
            exmem_we  = 1'b0;
            memwb_clr = 1'b1;
        end else if (redirect_act) begin
            // Squash the two wrong-path instructions; load-use is moot.
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else if (load_use) begin
            // Hold IF/ID for one cycle and send a bubble into EX.
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            idex_clr = 1'b1;
        end
        if (reset) begin
            pc_we     = 1'b0;
            ifid_we   = 1'b0;
            idex_we   = 1'b0;
            exmem_we  = 1'b0;
            memwb_we  = 1'b0;
            ifid_clr  = 1'b0;
            idex_clr  = 1'b0;
            exmem_clr = 1'b0;
            memwb_clr = 1'b0;
            mem_ready = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (!pc_we) begin
                stall_cycles <= stall_cycles + CNT_W'(1);
            end
            if (redirect_act) begin
                flush_events <= flush_events + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl. Three instances share one stimulus stream:
// MEM_LAT=2 (32-bit counters), MEM_LAT=3 (4-bit counters, exercises wrap)
// and MEM_LAT=0. A behavioural model of each is checked every cycle, and a
// directed prologue pins a few literal expectations before random traffic.
module tb_pipe_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
    logic       ex_mem_read = 1'b0, ex_redirect = 1'b0, mem_access = 1'b0;

    // {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
    //  ifid_clr, idex_clr, exmem_clr, memwb_clr, mem_ready}
    logic [9:0]  obs [3];
    logic [31:0] sc_o [3];
    logic [31:0] fe_o [3];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 2 : (gi == 1) ? 3 : 0;
        localparam int CW  = (gi == 1) ? 4 : 32;
        logic pc_we, ifid_we, idex_we, exmem_we, memwb_we;
        logic ifid_clr, idex_clr, exmem_clr, memwb_clr, mem_ready;
        logic [CW-1:0] stall_cycles, flush_events;
        pipe_ctrl #(.MEM_LAT(LAT), .CNT_W(CW)) dut (
            .clk(clk), .reset(reset),
            .id_rs1(id_rs1), .id_rs2(id_rs2),
            .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
            .ex_rd(ex_rd), .ex_mem_read(ex_mem_read),
            .ex_redirect(ex_redirect), .mem_access(mem_access),
            .pc_we(pc_we), .ifid_we(ifid_we), .idex_we(idex_we),
            .exmem_we(exmem_we), .memwb_we(memwb_we),
            .ifid_clr(ifid_clr), .idex_clr(idex_clr),
            .exmem_clr(exmem_clr), .memwb_clr(memwb_clr),
            .mem_ready(mem_ready),
            .stall_cycles(stall_cycles), .flush_events(flush_events)
        );
        assign obs[gi] = {pc_we, ifid_we, idex_we, exmem_we, memwb_we,
                          ifid_clr, idex_clr, exmem_clr, memwb_clr, mem_ready};
        assign sc_o[gi] = 32'(stall_cycles);
        assign fe_o[gi] = 32'(flush_events);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each memory op is tracked as "stall cycles served so far"; once
    // MEM_LAT have been served, the next cycle is the ready cycle.
    int          lat_m [3] = '{2, 3, 0};
    int          cw_m  [3] = '{32, 4, 32};
    int          done_m [3] = '{0, 0, 0};
    bit          rdy_m  [3] = '{0, 0, 0};
    logic [31:0] sc_m   [3] = '{0, 0, 0};
    logic [31:0] fe_m   [3] = '{0, 0, 0};
    int          done_n [3];
    bit          rdy_n  [3];
    logic [31:0] sc_n   [3];
    logic [31:0] fe_n   [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [9:0]  ev;
            logic [31:0] mask;
            bit ms, rdy, lu, redir;
            mask = (cw_m[i] == 32) ? 32'hFFFF_FFFF : ((32'd1 << cw_m[i]) - 32'd1);
            if (reset) begin
                chk($sformatf("model_out%0d", i), {22'd0, obs[i]}, 32'd0);
                chk($sformatf("model_stall%0d", i), sc_o[i], 32'd0);
                chk($sformatf("model_flush%0d", i), fe_o[i], 32'd0);
                done_n[i] = 0; rdy_n[i] = 0; sc_n[i] = 0; fe_n[i] = 0;
            end else begin
                if (lat_m[i] == 0) begin
                    ms = 0; rdy = mem_access;
                end else if (rdy_m[i]) begin
                    ms = 0; rdy = 1;
                end else if (done_m[i] > 0) begin
                    ms = 1; rdy = 0;
                end else begin
                    ms = mem_access; rdy = 0;
                end
                lu = ex_mem_read && ex_rd != 0 &&
                     ((id_use_rs1 && ex_rd == id_rs1) || (id_use_rs2 && ex_rd == id_rs2));
                redir = ex_redirect && !ms;
                if (ms)         ev = {5'b00001, 4'b0001, rdy};
                else if (redir) ev = {5'b11111, 4'b1100, rdy};
                else if (lu)    ev = {5'b00111, 4'b0100, rdy};
                else            ev = {5'b11111, 4'b0000, rdy};
                chk($sformatf("model_out%0d", i), {22'd0, obs[i]}, {22'd0, ev});
                chk($sformatf("model_stall%0d", i), sc_o[i], sc_m[i]);
                chk($sformatf("model_flush%0d", i), fe_o[i], fe_m[i]);
                sc_n[i] = (sc_m[i] + (ev[9] ? 32'd0 : 32'd1)) & mask;
                fe_n[i] = (fe_m[i] + (redir ? 32'd1 : 32'd0)) & mask;
                done_n[i] = done_m[i];
                rdy_n[i]  = 0;
                if (ms) begin
                    if (done_m[i] + 1 == lat_m[i]) begin
                        done_n[i] = 0; rdy_n[i] = 1;
                    end else begin
                        done_n[i] = done_m[i] + 1;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                done_m[i] <= 0; rdy_m[i] <= 0; sc_m[i] <= 0; fe_m[i] <= 0;
            end else begin
                done_m[i] <= done_n[i]; rdy_m[i] <= rdy_n[i];
                sc_m[i] <= sc_n[i]; fe_m[i] <= fe_n[i];
            end
        end
    end

    // ---------------- stimulus ----------------
    localparam logic [9:0] NORMAL  = 10'b11111_0000_0;
    localparam logic [9:0] LU      = 10'b00111_0100_0;
    localparam logic [9:0] REDIR   = 10'b11111_1100_0;
    localparam logic [9:0] MSTALL  = 10'b00001_0001_0;
    localparam logic [9:0] READY   = 10'b11111_0000_1;
    localparam logic [9:0] REDIR_R = 10'b11111_1100_1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
        id_use_rs1 = 0; id_use_rs2 = 0;
        ex_mem_read = 0; ex_redirect = 0; mem_access = 0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        look();
        chk("reset_out", {22'd0, obs[0]}, 32'd0);
        chk("reset_stall", sc_o[0], 32'd0);
        step();
        reset = 1'b0;
        look();
        chk("run_normal", {22'd0, obs[0]}, {22'd0, NORMAL});
        step();

        // Load-use on rs1
        ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
        look();
        chk("loaduse_out", {22'd0, obs[0]}, {22'd0, LU});
        step();
        idle();
        look();
        chk("after_loaduse", {22'd0, obs[0]}, {22'd0, NORMAL});
        chk("loaduse_stall_cnt", sc_o[0], 32'd1);
        step();

        // x0 destination and unused rs2 never stall
        ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
        look();
        chk("x0_nostall", {22'd0, obs[0]}, {22'd0, NORMAL});
        step();
        ex_rd = 7; id_rs1 = 1; id_rs2 = 7; id_use_rs2 = 0;
        look();
        chk("unused_rs2", {22'd0, obs[0]}, {22'd0, NORMAL});
        step();

        // Redirect wins over load-use
        ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; ex_redirect = 1;
        look();
        chk("redir_over_lu", {22'd0, obs[0]}, {22'd0, REDIR});
        step();
        idle();
        look();
        chk("redir_flush_cnt", fe_o[0], 32'd1);
        chk("redir_stall_cnt", sc_o[0], 32'd1);
        step();

        // MEM_LAT=2, mem_access held: stall, stall, ready, stall, stall, ready
        mem_access = 1;
        for (int c = 0; c < 6; c++) begin
            look();
            chk($sformatf("mem2_c%0d", c), {22'd0, obs[0]},
                {22'd0, (c % 3 == 2) ? READY : MSTALL});
            step();
        end
        idle();
        look();
        chk("mem2_stall_cnt", sc_o[0], 32'd5);
        step();
        for (int c = 0; c < 4; c++) step();

        // MEM_LAT=3 with redirect held through the stall
        mem_access = 1; ex_redirect = 1;
        for (int c = 0; c < 4; c++) begin
            look();
            chk($sformatf("mem3_redir_c%0d", c), {22'd0, obs[1]},
                {22'd0, (c < 3) ? MSTALL : REDIR_R});
            step();
            mem_access = 0;
        end
        idle();
        step();

        // Reset in the middle of a MEM_LAT=2 wait
        mem_access = 1;
        step();
        mem_access = 0;
        reset = 1;
        look();
        chk("midwait_reset_out", {22'd0, obs[0]}, 32'd0);
        chk("midwait_reset_cnt", sc_o[0] | fe_o[0], 32'd0);
        step();
        reset = 0;
        look();
        chk("after_reset_run", {22'd0, obs[0]}, {22'd0, NORMAL});
        step();

        // MEM_LAT=0: ready follows access, no stall
        mem_access = 1;
        look();
        chk("lat0_ready", {22'd0, obs[2]}, {22'd0, READY});
        step();
        idle();
        step();

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            id_rs1      = 5'($urandom_range(0, 3));
            id_rs2      = 5'($urandom_range(0, 3));
            ex_rd       = 5'($urandom_range(0, 3));
            id_use_rs1  = 1'($urandom_range(0, 1));
            id_use_rs2  = 1'($urandom_range(0, 1));
            ex_mem_read = 1'($urandom_range(0, 1));
            ex_redirect = ($urandom_range(0, 5) == 0);
            mem_access  = ($urandom_range(0, 3) == 0);
            reset       = ($urandom_range(0, 199) == 0);
            step();
        end
        reset = 0;
        idle();
        step();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller for the five-stage RV core. It drives the write_enable and clr inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipe_reg instances, plus the PC enable. It resolves three event classes into stall and flush actions: load-use hazards, EX-stage control redirects, and multi-cycle data-memory accesses. It also keeps stall and flush performance counters.

Parameters:
MEM_LAT, 2, stall cycles per load/store in MEM; 0 means single-cycle memory and no stall.
CNT_W, 32, width of the performance counters.

Ports:
clk  in  1  pipeline clock, rising edge.
reset  in  1  asynchronous, active-high reset.
id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads rs1 / rs2.
ex_rd  in  5  destination register of the instruction in EX.
ex_mem_read  in  1  instruction in EX is a load.
ex_redirect  in  1  taken branch or jump resolved in EX.
mem_access  in  1  instruction in MEM is a load or store.
pc_we  out  1  PC register enable.
ifid_we, idex_we, exmem_we, memwb_we  out  1 each  pipe_reg write enables.
ifid_clr, idex_clr, exmem_clr, memwb_clr  out  1 each  pipe_reg clears (bubble insert).
mem_ready  out  1  data memory result is valid this cycle.
stall_cycles  out  CNT_W  count of cycles with pc_we=0.
flush_events  out  CNT_W  count of cycles with ex_redirect acted on.

Behaviour:
- Reset, asynchronous: state=RUN, wait counter=0, both perf counters=0.
- While reset is high, every *_we, *_clr and mem_ready output is 0.
- Default when no event (RUN, no hazard): all *_we=1, all *_clr=0.
- FSM states: RUN, WAIT, RELEASE. The wait counter is ceil(log2(MEM_LAT+1)) bits wide.
- RUN, when mem_access=1 and MEM_LAT>0:
  - This is a mem-stall cycle.
  - Next state is RELEASE if MEM_LAT==1; otherwise WAIT with counter=MEM_LAT-1.
- WAIT:
  - Every cycle is a mem-stall cycle and the counter decrements.
  - Goes to RELEASE when the counter equals 1 at the clock edge.
- RELEASE:
  - Lasts exactly one cycle; mem_ready=1 and mem_access is ignored.
  - Normal redirect and load-use rules apply; returns to RUN.
- MEM_LAT==0: the FSM never leaves RUN and mem_ready = mem_access.
- Total stall per memory op is exactly MEM_LAT cycles. Back-to-back memory ops each stall MEM_LAT cycles, separated by the RELEASE cycle.
- Mem-stall cycle, highest priority:
  - pc_we = ifid_we = idex_we = exmem_we = 0.
  - memwb_clr=1, which inserts a bubble into WB.
  - ex_redirect and the load-use condition are ignored; they re-present after the stall because EX and ID are frozen.
- Redirect (ex_redirect=1, no mem-stall):
  - pc_we=1 (PC loads the target), ifid_clr=1, idex_clr=1.
  - Load-use is ignored because the ID instruction is squashed.
  - flush_events increments.
- Load-use, lowest priority:
  - Condition: ex_mem_read=1, ex_rd!=0, and (ex_rd==id_rs1 with id_use_rs1) or (ex_rd==id_rs2 with id_use_rs2).
  - Action: pc_we=0, ifid_we=0, idex_clr=1. EX/MEM and MEM/WB advance.
  - Stalls exactly 1 cycle: the load has moved to MEM on the next cycle.
- A rd of x0 never causes a stall.
- clr is never asserted on a register whose we=0 in the same cycle, except memwb during a mem-stall (memwb_we=1 there).
- stall_cycles increments on every non-reset cycle with pc_we=0. flush_events increments per acted-on redirect. Both counters wrap modulo 2^CNT_W.
- Reset asserted in WAIT or RELEASE aborts the access. After release: RUN, counter 0, no residual stall.
- All outputs are combinational from the state and the inputs. There are no registered outputs other than the counters.

Test Plan:
- Load-use: ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> one cycle with pc_we=0, ifid_we=0, idex_clr=1; next cycle all we=1; stall_cycles=1.
- x0 and unused operand: ex_rd=0 matching id_rs1, then ex_rd=7 with id_rs2=7 and id_use_rs2=0 -> no stall in either case.
- Redirect during load-use: ex_redirect=1 with the load-use condition true -> pc_we=1, ifid_clr=1, idex_clr=1; flush_events=1; stall_cycles unchanged.
- Memory stall, MEM_LAT=2: mem_access held high -> exactly 2 cycles with pc_we=exmem_we=0 and memwb_clr=1; third cycle mem_ready=1 with all we=1; back-to-back second op stalls 2 more cycles.
- Redirect during mem-stall: ex_redirect=1 throughout the MEM_LAT=3 stall -> no clr asserted for 3 cycles; flush applied in RELEASE; flush_events=1.
- Reset mid-WAIT: assert reset while counter=1 -> all outputs 0, counters 0; after release with mem_access=0, all we=1. Repeat with MEM_LAT=0: mem_ready follows mem_access and there is never a stall.
